// File: rtl/pipe_ctrl_unit.sv
// Control unit for the 5-stage RV32I pipeline: ID decode, ID/EX, EX/MEM and MEM/WB
// control registers, load-use stall and branch/jump flush generation.
module pipe_ctrl_unit #(
   parameter int unsigned REG_AW    = 5,
   parameter int unsigned ALUCTRL_W = 4,
   parameter int unsigned EN_BRANCH = 1,
   parameter int unsigned EN_HAZARD = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [6:0]           opcode_d,
   input  logic [2:0]           funct3_d,
   input  logic                 funct75_d,
   input  logic [REG_AW-1:0]    rs1_d,
   input  logic [REG_AW-1:0]    rs2_d,
   input  logic [REG_AW-1:0]    rd_d,
   input  logic                 cond_e,
   output logic [1:0]           immsrc_d,
   output logic                 illegal_d,
   output logic [ALUCTRL_W-1:0] alucontrol_e,
   output logic                 alusrc_e,
   output logic [2:0]           funct3_e,
   output logic                 pcsrc_e,
   output logic                 memwrite_m,
   output logic                 regwrite_w,
   output logic [1:0]           resultsrc_w,
   output logic [REG_AW-1:0]    rd_w,
   output logic                 stall_f,
   output logic                 stall_d,
   output logic                 flush_d,
   output logic                 flush_e
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [ALUCTRL_W-1:0] ALU_ADD  = ALUCTRL_W'(4'b0000);
   localparam logic [ALUCTRL_W-1:0] ALU_SUB  = ALUCTRL_W'(4'b0001);
   localparam logic [ALUCTRL_W-1:0] ALU_SLL  = ALUCTRL_W'(4'b0010);
   localparam logic [ALUCTRL_W-1:0] ALU_SLT  = ALUCTRL_W'(4'b0011);
   localparam logic [ALUCTRL_W-1:0] ALU_SLTU = ALUCTRL_W'(4'b0100);
   localparam logic [ALUCTRL_W-1:0] ALU_XOR  = ALUCTRL_W'(4'b0101);
   localparam logic [ALUCTRL_W-1:0] ALU_SRL  = ALUCTRL_W'(4'b0110);
   localparam logic [ALUCTRL_W-1:0] ALU_SRA  = ALUCTRL_W'(4'b0111);
   localparam logic [ALUCTRL_W-1:0] ALU_OR   = ALUCTRL_W'(4'b1000);
   localparam logic [ALUCTRL_W-1:0] ALU_AND  = ALUCTRL_W'(4'b1001);

   logic                 regwrite_d, memwrite_d, branch_d, jump_d, alusrc_d;
   logic [1:0]           resultsrc_d;
   logic [ALUCTRL_W-1:0] alu_fn, alucontrol_d;

   logic                 regwrite_e, memwrite_e, branch_e, jump_e;
   logic [1:0]           resultsrc_e;
   logic [REG_AW-1:0]    rd_e;
   logic                 regwrite_m;
   logic [1:0]           resultsrc_m;
   logic [REG_AW-1:0]    rd_m;
   logic                 use_rs1, use_rs2, load_use;

   // funct7[5] only selects SUB for R-type; for I-type it is an immediate bit except on shifts
   always_comb begin
      alu_fn = ALU_ADD;
      unique case (funct3_d)
         3'b000:  alu_fn = (opcode_d == OP_R && funct75_d) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_fn = ALU_SLL;
         3'b010:  alu_fn = ALU_SLT;
         3'b011:  alu_fn = ALU_SLTU;
         3'b100:  alu_fn = ALU_XOR;
         3'b101:  alu_fn = funct75_d ? ALU_SRA : ALU_SRL;
         3'b110:  alu_fn = ALU_OR;
         default: alu_fn = ALU_AND;
      endcase
   end

   always_comb begin
      regwrite_d   = 1'b0;
      memwrite_d   = 1'b0;
      branch_d     = 1'b0;
      jump_d       = 1'b0;
      alusrc_d     = 1'b0;
      resultsrc_d  = 2'b00;
      immsrc_d     = 2'b00;
      alucontrol_d = ALU_ADD;
      illegal_d    = 1'b0;
      case (opcode_d)
         OP_R: begin
            regwrite_d   = 1'b1;
            alucontrol_d = alu_fn;
         end
         OP_I: begin
            regwrite_d   = 1'b1;
            alusrc_d     = 1'b1;
            alucontrol_d = alu_fn;
         end
         OP_LOAD: begin
            regwrite_d  = 1'b1;
            alusrc_d    = 1'b1;
            resultsrc_d = 2'b01;
         end
         OP_STORE: begin
            memwrite_d = 1'b1;
            alusrc_d   = 1'b1;
            immsrc_d   = 2'b01;
         end
         OP_BRANCH: begin
            if (EN_BRANCH != 0) begin
               branch_d     = 1'b1;
               alucontrol_d = ALU_SUB;
               immsrc_d     = 2'b10;
            end else begin
               illegal_d = 1'b1;
            end
         end
         OP_JAL: begin
            if (EN_BRANCH != 0) begin
               jump_d      = 1'b1;
               regwrite_d  = 1'b1;
               resultsrc_d = 2'b10;
               immsrc_d    = 2'b11;
            end else begin
               illegal_d = 1'b1;
            end
         end
         default: illegal_d = 1'b1;
      endcase
   end

   assign use_rs1  = (opcode_d != OP_JAL);
   assign use_rs2  = (opcode_d == OP_R) || (opcode_d == OP_STORE) || (opcode_d == OP_BRANCH);
   assign load_use = (EN_HAZARD != 0) && (resultsrc_e == 2'b01) && (rd_e != '0) &&
                     ((use_rs1 && rs1_d == rd_e) || (use_rs2 && rs2_d == rd_e));

   assign pcsrc_e = jump_e | (branch_e & cond_e);

   // A redirect makes the stalled ID instruction dead, so flush overrides stall
   always_comb begin
      stall_f = load_use & ~pcsrc_e;
      stall_d = load_use & ~pcsrc_e;
      flush_d = pcsrc_e;
      flush_e = pcsrc_e | load_use;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regwrite_e   <= 1'b0;
         memwrite_e   <= 1'b0;
         branch_e     <= 1'b0;
         jump_e       <= 1'b0;
         alusrc_e     <= 1'b0;
         resultsrc_e  <= 2'b00;
         alucontrol_e <= '0;
         funct3_e     <= '0;
         rd_e         <= '0;
      end else if (flush_e) begin
         regwrite_e   <= 1'b0;
         memwrite_e   <= 1'b0;
         branch_e     <= 1'b0;
         jump_e       <= 1'b0;
         alusrc_e     <= 1'b0;
         resultsrc_e  <= 2'b00;
         alucontrol_e <= '0;
         funct3_e     <= '0;
         rd_e         <= '0;
      end else begin
         regwrite_e   <= regwrite_d;
         memwrite_e   <= memwrite_d;
         branch_e     <= branch_d;
         jump_e       <= jump_d;
         alusrc_e     <= alusrc_d;
         resultsrc_e  <= resultsrc_d;
         alucontrol_e <= alucontrol_d;
         funct3_e     <= illegal_d ? 3'b000 : funct3_d;
         rd_e         <= illegal_d ? '0 : rd_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regwrite_m  <= 1'b0;
         memwrite_m  <= 1'b0;
         resultsrc_m <= 2'b00;
         rd_m        <= '0;
         regwrite_w  <= 1'b0;
         resultsrc_w <= 2'b00;
         rd_w        <= '0;
      end else begin
         regwrite_m  <= regwrite_e;
         memwrite_m  <= memwrite_e;
         resultsrc_m <= resultsrc_e;
         rd_m        <= rd_e;
         regwrite_w  <= regwrite_m;
         resultsrc_w <= resultsrc_m;
         rd_w        <= rd_m;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: main instance with all features, and a second
// instance with branch decode and hazard logic disabled.
module tb_pipe_ctrl_unit;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] opcode_d;
   logic [2:0] funct3_d;
   logic       funct75_d;
   logic [4:0] rs1_d, rs2_d, rd_d;
   logic       cond_e;

   logic [1:0] immsrc_d, resultsrc_w;
   logic       illegal_d, alusrc_e, pcsrc_e, memwrite_m, regwrite_w;
   logic [3:0] alucontrol_e;
   logic [2:0] funct3_e;
   logic [4:0] rd_w;
   logic       stall_f, stall_d, flush_d, flush_e;

   logic [1:0] immsrc_nb, resultsrc_nb;
   logic       illegal_nb, alusrc_nb, pcsrc_nb, memwrite_nb, regwrite_nb;
   logic [3:0] alucontrol_nb;
   logic [2:0] funct3_nb;
   logic [4:0] rd_nb;
   logic       stall_f_nb, stall_d_nb, flush_d_nb, flush_e_nb;

   int errors = 0;
   int checks = 0;

   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;

   pipe_ctrl_unit #(.REG_AW(5), .ALUCTRL_W(4), .EN_BRANCH(1), .EN_HAZARD(1)) dut (
      .clk(clk), .rst_n(rst_n), .opcode_d(opcode_d), .funct3_d(funct3_d), .funct75_d(funct75_d),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .cond_e(cond_e), .immsrc_d(immsrc_d),
      .illegal_d(illegal_d), .alucontrol_e(alucontrol_e), .alusrc_e(alusrc_e), .funct3_e(funct3_e),
      .pcsrc_e(pcsrc_e), .memwrite_m(memwrite_m), .regwrite_w(regwrite_w), .resultsrc_w(resultsrc_w),
      .rd_w(rd_w), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e));

   pipe_ctrl_unit #(.REG_AW(5), .ALUCTRL_W(4), .EN_BRANCH(0), .EN_HAZARD(0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .opcode_d(opcode_d), .funct3_d(funct3_d), .funct75_d(funct75_d),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .cond_e(cond_e), .immsrc_d(immsrc_nb),
      .illegal_d(illegal_nb), .alucontrol_e(alucontrol_nb), .alusrc_e(alusrc_nb), .funct3_e(funct3_nb),
      .pcsrc_e(pcsrc_nb), .memwrite_m(memwrite_nb), .regwrite_w(regwrite_nb), .resultsrc_w(resultsrc_nb),
      .rd_w(rd_nb), .stall_f(stall_f_nb), .stall_d(stall_d_nb), .flush_d(flush_d_nb), .flush_e(flush_e_nb));

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic set_id(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
      opcode_d = op; funct3_d = f3; funct75_d = f75; rs1_d = r1; rs2_d = r2; rd_d = rd;
      #1;
   endtask

   task automatic nop();
      set_id(OP_I, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      set_id(OP_ST, 3'b010, 1'b0, 5'd1, 5'd2, 5'd0);
      tick();
      set_id(OP_JAL, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1);
      tick();
      nop();
      checks++; if (memwrite_m !== 1'b1) begin errors++; $display("FAIL pre_reset_memwrite: got %b exp 1", memwrite_m); end
      checks++; if (pcsrc_e !== 1'b1) begin errors++; $display("FAIL pre_reset_pcsrc: got %b exp 1", pcsrc_e); end
      rst_n = 1'b0;
      #1;
      checks++; if (memwrite_m !== 1'b0) begin errors++; $display("FAIL rst_memwrite: got %b exp 0", memwrite_m); end
      checks++; if (pcsrc_e !== 1'b0) begin errors++; $display("FAIL rst_pcsrc: got %b exp 0", pcsrc_e); end
      checks++; if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0000) begin errors++; $display("FAIL rst_hazard: got %b exp 0000", {stall_f, stall_d, flush_d, flush_e}); end
      checks++; if (regwrite_w !== 1'b0) begin errors++; $display("FAIL rst_regwrite: got %b exp 0", regwrite_w); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if ({regwrite_w, memwrite_m, alucontrol_e, rd_w} !== 11'd0) begin errors++; $display("FAIL rst_release: got %b exp 0", {regwrite_w, memwrite_m, alucontrol_e, rd_w}); end
      tick();
   endtask

   task automatic test_r_seq();
      logic [6:0] ops [10] = '{OP_R, OP_I, OP_R, OP_I, OP_R, OP_R, OP_R, OP_R, OP_R, OP_R};
      logic [2:0] f3s [10] = '{3'b000, 3'b000, 3'b101, 3'b101, 3'b100, 3'b110, 3'b111, 3'b011, 3'b010, 3'b001};
      logic       f75s[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [3:0] exps[10] = '{4'b0000, 4'b0000, 4'b0110, 4'b0110, 4'b0101, 4'b1000, 4'b1001, 4'b0100, 4'b0011, 4'b0010};
      set_id(OP_R, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3);
      checks++; if (illegal_d !== 1'b0) begin errors++; $display("FAIL sub_illegal: got %b exp 0", illegal_d); end
      tick();
      nop();
      checks++; if (alucontrol_e !== 4'b0001) begin errors++; $display("FAIL sub_alu: got %b exp 0001", alucontrol_e); end
      checks++; if (alusrc_e !== 1'b0) begin errors++; $display("FAIL sub_alusrc: got %b exp 0", alusrc_e); end
      tick();
      tick();
      checks++; if (regwrite_w !== 1'b1) begin errors++; $display("FAIL sub_regwrite_w: got %b exp 1", regwrite_w); end
      checks++; if (rd_w !== 5'd3) begin errors++; $display("FAIL sub_rd_w: got %0d exp 3", rd_w); end
      checks++; if (resultsrc_w !== 2'b00) begin errors++; $display("FAIL sub_resultsrc_w: got %b exp 00", resultsrc_w); end
      set_id(OP_I, 3'b101, 1'b1, 5'd1, 5'd0, 5'd4);
      checks++; if (immsrc_d !== 2'b00) begin errors++; $display("FAIL srai_immsrc: got %b exp 00", immsrc_d); end
      tick();
      checks++; if (alucontrol_e !== 4'b0111) begin errors++; $display("FAIL srai_alu: got %b exp 0111", alucontrol_e); end
      checks++; if (alusrc_e !== 1'b1) begin errors++; $display("FAIL srai_alusrc: got %b exp 1", alusrc_e); end
      for (int i = 0; i < 10; i++) begin
         set_id(ops[i], f3s[i], f75s[i], 5'd0, 5'd0, 5'd0);
         tick();
         checks++; if (alucontrol_e !== exps[i]) begin errors++; $display("FAIL alu_table[%0d]: got %b exp %b", i, alucontrol_e, exps[i]); end
      end
      nop();
   endtask

   task automatic test_load_use();
      set_id(OP_LD, 3'b010, 1'b1, 5'd1, 5'd0, 5'd5);
      tick();
      checks++; if ({alucontrol_e, alusrc_e} !== 5'b00001) begin errors++; $display("FAIL lw_alu: got %b exp 00001", {alucontrol_e, alusrc_e}); end
      set_id(OP_R, 3'b000, 1'b0, 5'd5, 5'd1, 5'd6);
      checks++; if ({stall_f, stall_d, flush_d, flush_e} !== 4'b1101) begin errors++; $display("FAIL lu_hazard: got %b exp 1101", {stall_f, stall_d, flush_d, flush_e}); end
      checks++; if ({stall_f_nb, flush_e_nb} !== 2'b00) begin errors++; $display("FAIL lu_nohazard_param: got %b exp 00", {stall_f_nb, flush_e_nb}); end
      tick();
      checks++; if ({stall_f, stall_d, flush_e} !== 3'b000) begin errors++; $display("FAIL lu_one_cycle: got %b exp 000", {stall_f, stall_d, flush_e}); end
      tick();
      nop();
      checks++; if ({regwrite_w, resultsrc_w, rd_w} !== {1'b1, 2'b01, 5'd5}) begin errors++; $display("FAIL lw_wb: got %b exp 1_01_00101", {regwrite_w, resultsrc_w, rd_w}); end
      tick();
      checks++; if ({regwrite_w, rd_w} !== 6'd0) begin errors++; $display("FAIL lu_bubble_wb: got %b exp 0", {regwrite_w, rd_w}); end
      tick();
      checks++; if ({regwrite_w, rd_w} !== {1'b1, 5'd6}) begin errors++; $display("FAIL add_late_wb: got %b exp 1_00110", {regwrite_w, rd_w}); end
      set_id(OP_LD, 3'b010, 1'b0, 5'd0, 5'd0, 5'd7);
      tick();
      set_id(OP_ST, 3'b010, 1'b0, 5'd0, 5'd7, 5'd0);
      checks++; if (stall_f !== 1'b1) begin errors++; $display("FAIL lu_store_rs2: got %b exp 1", stall_f); end
      tick();
      tick();
      set_id(OP_LD, 3'b010, 1'b0, 5'd0, 5'd0, 5'd7);
      tick();
      set_id(OP_I, 3'b000, 1'b0, 5'd0, 5'd7, 5'd8);
      checks++; if (stall_f !== 1'b0) begin errors++; $display("FAIL lu_itype_rs2: got %b exp 0", stall_f); end
      tick();
      set_id(OP_LD, 3'b010, 1'b0, 5'd1, 5'd0, 5'd0);
      tick();
      set_id(OP_R, 3'b000, 1'b0, 5'd0, 5'd0, 5'd9);
      checks++; if ({stall_f, flush_e} !== 2'b00) begin errors++; $display("FAIL lu_x0: got %b exp 00", {stall_f, flush_e}); end
      tick();
      set_id(OP_LD, 3'b010, 1'b0, 5'd1, 5'd0, 5'd5);
      tick();
      set_id(OP_JAL, 3'b000, 1'b0, 5'd5, 5'd5, 5'd0);
      checks++; if (stall_f !== 1'b0) begin errors++; $display("FAIL lu_jal: got %b exp 0", stall_f); end
      tick();
      nop();
      tick();
   endtask

   task automatic test_branch();
      set_id(OP_BR, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0);
      checks++; if ({immsrc_d, illegal_d, illegal_nb} !== 4'b1001) begin errors++; $display("FAIL beq_decode: got %b exp 1001", {immsrc_d, illegal_d, illegal_nb}); end
      tick();
      cond_e = 1'b1;
      nop();
      checks++; if ({pcsrc_e, flush_d, flush_e, stall_f, stall_d} !== 5'b11100) begin errors++; $display("FAIL beq_taken: got %b exp 11100", {pcsrc_e, flush_d, flush_e, stall_f, stall_d}); end
      checks++; if ({alucontrol_e, funct3_e} !== 7'b0001000) begin errors++; $display("FAIL beq_ex: got %b exp 0001000", {alucontrol_e, funct3_e}); end
      checks++; if (pcsrc_nb !== 1'b0) begin errors++; $display("FAIL beq_nobranch_param: got %b exp 0", pcsrc_nb); end
      tick();
      checks++; if ({pcsrc_e, flush_d, flush_e} !== 3'b000) begin errors++; $display("FAIL beq_flush_bubble: got %b exp 000", {pcsrc_e, flush_d, flush_e}); end
      cond_e = 1'b0;
      set_id(OP_BR, 3'b001, 1'b0, 5'd1, 5'd2, 5'd0);
      tick();
      nop();
      checks++; if ({funct3_e, pcsrc_e, flush_e} !== 5'b00100) begin errors++; $display("FAIL bne_not_taken: got %b exp 00100", {funct3_e, pcsrc_e, flush_e}); end
      tick();
      tick();
      checks++; if (regwrite_w !== 1'b0) begin errors++; $display("FAIL bne_regwrite_w: got %b exp 0", regwrite_w); end
   endtask

   task automatic test_jal();
      set_id(OP_JAL, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1);
      checks++; if ({immsrc_d, illegal_d, illegal_nb} !== 4'b1101) begin errors++; $display("FAIL jal_decode: got %b exp 1101", {immsrc_d, illegal_d, illegal_nb}); end
      tick();
      cond_e = 1'b0;
      nop();
      checks++; if ({pcsrc_e, flush_d, flush_e} !== 3'b111) begin errors++; $display("FAIL jal_redirect: got %b exp 111", {pcsrc_e, flush_d, flush_e}); end
      checks++; if (pcsrc_nb !== 1'b0) begin errors++; $display("FAIL jal_nobranch_param: got %b exp 0", pcsrc_nb); end
      tick();
      tick();
      checks++; if ({regwrite_w, resultsrc_w, rd_w} !== {1'b1, 2'b10, 5'd1}) begin errors++; $display("FAIL jal_wb: got %b exp 1_10_00001", {regwrite_w, resultsrc_w, rd_w}); end
   endtask

   task automatic test_illegal();
      set_id(7'b1111111, 3'b000, 1'b0, 5'd0, 5'd0, 5'd9);
      checks++; if (illegal_d !== 1'b1) begin errors++; $display("FAIL illegal_flag: got %b exp 1", illegal_d); end
      checks++; if ({stall_f, flush_e} !== 2'b00) begin errors++; $display("FAIL illegal_nostall: got %b exp 00", {stall_f, flush_e}); end
      tick();
      nop();
      checks++; if ({alusrc_e, pcsrc_e, alucontrol_e} !== 6'd0) begin errors++; $display("FAIL illegal_ex: got %b exp 0", {alusrc_e, pcsrc_e, alucontrol_e}); end
      tick();
      checks++; if (memwrite_m !== 1'b0) begin errors++; $display("FAIL illegal_mem: got %b exp 0", memwrite_m); end
      tick();
      checks++; if ({regwrite_w, rd_w} !== 6'd0) begin errors++; $display("FAIL illegal_wb: got %b exp 0", {regwrite_w, rd_w}); end
   endtask

   initial begin
      rst_n  = 1'b0;
      cond_e = 1'b0;
      nop();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      test_reset();
      test_r_seq();
      test_load_use();
      test_branch();
      test_jal();
      test_illegal();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
